// File: rtl/clk_period_monitor_pkg.sv
// Shared types for the clock period monitor: FSM state encoding and result record.
package clks_alot_p;

    localparam int RATE_COUNTER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        HIGH,
        LOW
    } clk_mon_state_e;

    typedef struct packed {
        logic [RATE_COUNTER_WIDTH-1:0] high;
        logic [RATE_COUNTER_WIDTH-1:0] low;
        logic                          saturated;
        logic                          match;
    } clk_mon_result_s;

endpackage

// File: rtl/clk_period_monitor_edge.sv
// Optional synchronizer chain plus previous-sample flop; emits level and edge
// strobes for the monitored clock, advancing only on enabled system cycles.
module clk_edge_detect #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic async_rst,
    input  logic clk_en,
    input  logic mon_clk_i,
    output logic s,
    output logic rise,
    output logic fall
);

    logic prev;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s = mon_clk_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or posedge async_rst) begin
                if (async_rst) begin
                    sync_q <= '0;
                end else if (clk_en) begin
                    sync_q[0] <= mon_clk_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            prev <= 1'b0;
        end else if (clk_en) begin
            prev <= s;
        end
    end

    assign rise = s & ~prev;
    assign fall = ~s & prev;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures high/low phase lengths of a generated clock in enabled system cycles
// and publishes one result per full period over a valid/ready handshake.
module clk_period_monitor
    import clks_alot_p::*;
#(
    parameter int RATE_COUNTER_WIDTH = clks_alot_p::RATE_COUNTER_WIDTH,
    parameter int SYNC_STAGES        = 0
) (
    input  logic                          clk,
    input  logic                          async_rst,
    input  logic                          clk_en,
    input  logic                          mon_clk_i,
    input  logic                          measure_en_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] exp_high_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] exp_low_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [RATE_COUNTER_WIDTH-1:0] high_count_o,
    output logic [RATE_COUNTER_WIDTH-1:0] low_count_o,
    output logic                          saturated_o,
    output logic                          match_o,
    output logic                          overrun_o,
    input  logic                          overrun_clr_i
);

    localparam int W = RATE_COUNTER_WIDTH;
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    clk_mon_state_e state;
    logic [W-1:0]   cnt;
    logic [W-1:0]   high_cap;
    logic           high_sat;
    logic           s, rise, fall;
    logic           accept;
    logic           low_sat;
    logic           period_sat;

    clk_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk      (clk),
        .async_rst(async_rst),
        .clk_en   (clk_en),
        .mon_clk_i(mon_clk_i),
        .s        (s),
        .rise     (rise),
        .fall     (fall)
    );

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign accept     = result_valid_o & result_ready_i;
    assign low_sat    = (cnt == CNT_MAX);
    assign period_sat = high_sat | low_sat;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            high_cap       <= '0;
            high_sat       <= 1'b0;
            result_valid_o <= 1'b0;
            high_count_o   <= '0;
            low_count_o    <= '0;
            saturated_o    <= 1'b0;
            match_o        <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            // Handshake runs every cycle; later assignments below take priority.
            if (accept) result_valid_o <= 1'b0;
            if (overrun_clr_i) overrun_o <= 1'b0;

            if (clk_en) begin
                if (!measure_en_i) begin
                    state    <= IDLE;
                    cnt      <= '0;
                    high_cap <= '0;
                    high_sat <= 1'b0;
                end else begin
                    case (state)
                        IDLE: state <= WAIT_RISE;
                        WAIT_RISE: begin
                            if (rise) begin
                                cnt   <= CNT_ONE;
                                state <= HIGH;
                            end
                        end
                        HIGH: begin
                            if (fall) begin
                                high_cap <= cnt;
                                high_sat <= (cnt == CNT_MAX);
                                cnt      <= CNT_ONE;
                                state    <= LOW;
                            end else if (s) begin
                                cnt <= sat_inc(cnt);
                            end
                        end
                        LOW: begin
                            if (rise) begin
                                if (!result_valid_o || accept) begin
                                    result_valid_o <= 1'b1;
                                    high_count_o   <= high_cap;
                                    low_count_o    <= cnt;
                                    saturated_o    <= period_sat;
                                    // A measured phase is never 0, but keep zero rates explicit.
                                    match_o        <= (high_cap == exp_high_i) && (cnt == exp_low_i)
                                                      && !period_sat && (exp_high_i != '0)
                                                      && (exp_low_i != '0);
                                end else begin
                                    overrun_o <= 1'b1;
                                end
                                cnt   <= CNT_ONE;
                                state <= HIGH;
                            end else if (!s) begin
                                cnt <= sat_inc(cnt);
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
